// File: rtl/fft_pkg.sv
// Shared types and helpers for the serial FFT stage: FSM states, complex word,
// log2 for sizing, and the fixed-point multiply used by the butterfly.
package fft_pkg;

  // Internal arithmetic width; exact for word widths up to 32 bits.
  localparam int ACC_W = 64;

  typedef enum logic [1:0] {RECV, COMP, SEND} state_e;

  typedef struct packed {
    logic signed [ACC_W-1:0] re;
    logic signed [ACC_W-1:0] im;
  } cplx_t;

  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Product is exact in ACC_W for sign-extended operands; the shift floors.
  function automatic logic signed [ACC_W-1:0] fx_mul(input logic signed [ACC_W-1:0] a,
                                                     input logic signed [ACC_W-1:0] b,
                                                     input int frac);
    return (a * b) >>> frac;
  endfunction

endpackage

// File: rtl/fft_stage_serial_if.sv
// Val/rdy stream bundle for the FFT stage: one input channel, one output channel.
interface fft_stage_serial_if #(
  parameter int BIT_WIDTH = 32
);
  logic [BIT_WIDTH-1:0] recv_msg;
  logic                 recv_val;
  logic                 recv_rdy;
  logic [BIT_WIDTH-1:0] send_msg;
  logic                 send_val;
  logic                 send_rdy;

  modport master (output recv_msg, recv_val, send_rdy,
                  input  recv_rdy, send_msg, send_val);

  modport slave  (input  recv_msg, recv_val, send_rdy,
                  output recv_rdy, send_msg, send_val);
endinterface

// File: rtl/fft_butterfly.sv
// Combinational radix-2 butterfly: top' = top + W*bot, bot' = top - W*bot.
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int DECIMAL_PT = 16
) (
  input  cplx_t top,
  input  cplx_t bot,
  input  cplx_t w,
  output cplx_t top_out,
  output cplx_t bot_out
);

  cplx_t wb;

  always_comb begin
    wb.re = fx_mul(bot.re, w.re, DECIMAL_PT) - fx_mul(bot.im, w.im, DECIMAL_PT);
    wb.im = fx_mul(bot.re, w.im, DECIMAL_PT) + fx_mul(bot.im, w.re, DECIMAL_PT);
    top_out.re = top.re + wb.re;
    top_out.im = top.im + wb.im;
    bot_out.re = top.re - wb.re;
    bot_out.im = top.im - wb.im;
  end

endmodule

// File: rtl/fft_stage_serial.sv
// Serial radix-2 FFT stage: collect a 2N-word frame, run N/2 in-place
// butterflies of the selected stage (or bypass), then stream the frame out.
module fft_stage_serial
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int N_SAMPLES  = 8,
  localparam int LOG2N = log2(N_SAMPLES),
  localparam int SEL_W = (log2(LOG2N) > 1) ? log2(LOG2N) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SEL_W-1:0]            stage_sel,
  input  logic                        bypass,
  input  logic signed [BIT_WIDTH-1:0] sine_wave_out [N_SAMPLES],
  fft_stage_serial_if.slave           io
);

  localparam int WORDS = 2 * N_SAMPLES;
  localparam int CNT_W = LOG2N + 1;
  localparam int BF_W  = LOG2N - 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BF_W-1:0]  LAST_BF   = BF_W'(N_SAMPLES / 2 - 1);
  localparam logic [BF_W-1:0]  BF_ONE    = BF_W'(1);
  localparam logic [LOG2N-1:0] IDX_ONE   = LOG2N'(1);
  localparam logic [LOG2N-1:0] QUARTER   = LOG2N'(N_SAMPLES / 4);
  localparam logic [SEL_W:0]   N_STAGES  = (SEL_W + 1)'(LOG2N);
  localparam logic [SEL_W-1:0] MAX_SHIFT = SEL_W'(LOG2N - 1);

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            word_cnt_q, word_cnt_d;
  logic [BF_W-1:0]             bf_cnt_q, bf_cnt_d;
  logic [SEL_W-1:0]            stage_q, stage_d;
  logic                        bypass_q, bypass_d;
  logic                        running_q, running_d;
  logic signed [BIT_WIDTH-1:0] mem_q [WORDS];
  logic signed [BIT_WIDTH-1:0] mem_d [WORDS];

  logic [LOG2N-1:0] k_ext, mask, top_idx, bot_idx, tw_idx, tw_re_idx;
  cplx_t            bf_top, bf_bot, bf_w, bf_top_out, bf_bot_out;

  // With m = 2^s, the low s bits of k are j and the rest select the group;
  // inserting a zero at bit s gives top, setting it gives bot.
  always_comb begin
    k_ext     = {1'b0, bf_cnt_q};
    mask      = (IDX_ONE << stage_q) - IDX_ONE;
    top_idx   = ((k_ext & ~mask) << 1) | (k_ext & mask);
    bot_idx   = top_idx | (IDX_ONE << stage_q);
    tw_idx    = (k_ext & mask) << (MAX_SHIFT - stage_q);
    tw_re_idx = tw_idx + QUARTER;

    bf_top.re = ACC_W'(mem_q[{1'b0, top_idx}]);
    bf_top.im = ACC_W'(mem_q[{1'b1, top_idx}]);
    bf_bot.re = ACC_W'(mem_q[{1'b0, bot_idx}]);
    bf_bot.im = ACC_W'(mem_q[{1'b1, bot_idx}]);
    bf_w.re   = ACC_W'(sine_wave_out[tw_re_idx]);
    bf_w.im   = -ACC_W'(sine_wave_out[tw_idx]);
  end

  fft_butterfly #(
    .DECIMAL_PT (DECIMAL_PT)
  ) u_butterfly (
    .top     (bf_top),
    .bot     (bf_bot),
    .w       (bf_w),
    .top_out (bf_top_out),
    .bot_out (bf_bot_out)
  );

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    bf_cnt_d    = bf_cnt_q;
    stage_d     = stage_q;
    bypass_d    = bypass_q;
    running_d   = 1'b1;
    mem_d       = mem_q;
    io.recv_rdy = 1'b0;
    io.send_val = 1'b0;
    io.send_msg = '0;

    unique case (state_q)
      RECV: begin
        io.recv_rdy = running_q;
        if (io.recv_val && running_q) begin
          mem_d[word_cnt_q] = io.recv_msg;
          if (word_cnt_q == '0) begin
            stage_d  = stage_sel;
            bypass_d = bypass || ({1'b0, stage_sel} >= N_STAGES);
          end
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = '0;
            state_d    = bypass_q ? SEND : COMP;
          end else begin
            word_cnt_d = word_cnt_q + CNT_ONE;
          end
        end
      end
      COMP: begin
        mem_d[{1'b0, top_idx}] = BIT_WIDTH'(bf_top_out.re);
        mem_d[{1'b1, top_idx}] = BIT_WIDTH'(bf_top_out.im);
        mem_d[{1'b0, bot_idx}] = BIT_WIDTH'(bf_bot_out.re);
        mem_d[{1'b1, bot_idx}] = BIT_WIDTH'(bf_bot_out.im);
        if (bf_cnt_q == LAST_BF) begin
          bf_cnt_d = '0;
          state_d  = SEND;
        end else begin
          bf_cnt_d = bf_cnt_q + BF_ONE;
        end
      end
      SEND: begin
        io.send_val = 1'b1;
        io.send_msg = mem_q[word_cnt_q];
        if (io.send_rdy) begin
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = '0;
            state_d    = RECV;
          end else begin
            word_cnt_d = word_cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RECV;
      word_cnt_q <= '0;
      bf_cnt_q   <= '0;
      stage_q    <= '0;
      bypass_q   <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      bf_cnt_q   <= bf_cnt_d;
      stage_q    <= stage_d;
      bypass_q   <= bypass_d;
      running_q  <= running_d;
    end
  end

  // Frame buffer carries no reset; a discarded frame is simply overwritten.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fft_stage_serial.sv
// Directed bench for fft_stage_serial: hand-computed impulse frames, bypass,
// backpressure with a small butterfly reference model, and mid-frame reset.
module tb_fft_stage_serial;

  localparam int BW    = 32;
  localparam int N     = 8;
  localparam int WORDS = 2 * N;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] stage_sel = 2'd0;
  logic       bypass = 1'b0;
  logic signed [BW-1:0] sine_tab [N] = '{32'sh00000000, 32'sh0000B504, 32'sh00010000, 32'sh0000B504,
                                         32'sh00000000, 32'shFFFF4AFC, 32'shFFFF0000, 32'shFFFF4AFC};

  int errors = 0;
  int checks = 0;
  logic [BW-1:0] in_frame  [WORDS];
  logic [BW-1:0] exp_frame [WORDS];

  fft_stage_serial_if #(.BIT_WIDTH(BW)) bus ();

  fft_stage_serial #(
    .BIT_WIDTH  (BW),
    .DECIMAL_PT (16),
    .N_SAMPLES  (N)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stage_sel     (stage_sel),
    .bypass        (bypass),
    .sine_wave_out (sine_tab),
    .io            (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_val(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Straight radix-2 stage over groups of 2m, applied in place.
  task automatic compute_ref(input int s, input logic byp);
    int m, tp, bt, t;
    longint wr, wi, ar, ai, br, bi, pr, pi;
    for (int i = 0; i < WORDS; i++) exp_frame[i] = in_frame[i];
    if (!byp && s < 3) begin
      m = 1 << s;
      for (int base = 0; base < N; base += 2 * m) begin
        for (int j = 0; j < m; j++) begin
          tp = base + j;
          bt = tp + m;
          t  = j * (N / (2 * m));
          wr = longint'(sine_tab[(t + N / 4) % N]);
          wi = -longint'(sine_tab[t]);
          ar = longint'($signed(exp_frame[tp]));
          ai = longint'($signed(exp_frame[N + tp]));
          br = longint'($signed(exp_frame[bt]));
          bi = longint'($signed(exp_frame[N + bt]));
          pr = ((br * wr) >>> 16) - ((bi * wi) >>> 16);
          pi = ((br * wi) >>> 16) + ((bi * wr) >>> 16);
          exp_frame[tp]     = 32'(ar + pr);
          exp_frame[N + tp] = 32'(ai + pi);
          exp_frame[bt]     = 32'(ar - pr);
          exp_frame[N + bt] = 32'(ai - pi);
        end
      end
    end
  endtask

  task automatic apply_stimulus(input int count, input int max_gap);
    int gap, waited;
    for (int i = 0; i < count; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      bus.recv_val = 1'b0;
      repeat (gap) step();
      bus.recv_msg = in_frame[i];
      bus.recv_val = 1'b1;
      waited = 0;
      while (!bus.recv_rdy && waited < 100) begin
        step();
        waited++;
      end
      if (waited >= 100) check_val($sformatf("recv_rdy_timeout_w%0d", i), {31'b0, bus.recv_rdy}, 32'd1);
      step();
      bus.recv_val = 1'b0;
    end
  endtask

  task automatic check_output(input string tag, input int stall_at, input int stall_len);
    int waited;
    for (int i = 0; i < WORDS; i++) begin
      waited = 0;
      while (!bus.send_val && waited < 100) begin
        step();
        waited++;
      end
      if (waited >= 100) check_val($sformatf("%s_val_timeout_w%0d", tag, i), {31'b0, bus.send_val}, 32'd1);
      check_val($sformatf("%s_w%0d", tag, i), bus.send_msg, exp_frame[i]);
      if (i == stall_at) begin
        bus.send_rdy = 1'b0;
        for (int c = 0; c < stall_len; c++) begin
          step();
          check_val($sformatf("%s_stall_msg_c%0d", tag, c), bus.send_msg, exp_frame[i]);
          check_val($sformatf("%s_stall_val_c%0d", tag, c), {31'b0, bus.send_val}, 32'd1);
        end
        bus.send_rdy = 1'b1;
      end
      step();
    end
    check_val($sformatf("%s_rdy_after", tag), {31'b0, bus.recv_rdy}, 32'd1);
    check_val($sformatf("%s_val_after", tag), {31'b0, bus.send_val}, 32'd0);
  endtask

  initial begin
    bus.recv_val = 1'b0;
    bus.recv_msg = '0;
    bus.send_rdy = 1'b1;

    // Reset state
    #2 reset = 1'b0;
    step();
    check_val("reset_recv_rdy", {31'b0, bus.recv_rdy}, 32'd0);
    check_val("reset_send_val", {31'b0, bus.send_val}, 32'd0);
    check_val("reset_send_msg", bus.send_msg, 32'd0);
    step();
    reset = 1'b1;
    step();
    check_val("post_reset_rdy", {31'b0, bus.recv_rdy}, 32'd1);

    // Stage 0, real impulse at 0
    stage_sel = 2'd0;
    bypass    = 1'b0;
    for (int i = 0; i < WORDS; i++) begin in_frame[i] = '0; exp_frame[i] = '0; end
    in_frame[0]  = 32'h00010000;
    exp_frame[0] = 32'h00010000;
    exp_frame[1] = 32'h00010000;
    apply_stimulus(WORDS, 0);
    check_val("comp_lat_e0", {31'b0, bus.send_val}, 32'd0);
    repeat (3) step();
    check_val("comp_lat_e3", {31'b0, bus.send_val}, 32'd0);
    step();
    check_val("comp_lat_e4", {31'b0, bus.send_val}, 32'd1);
    check_output("s0_impulse", -1, 0);

    // Stage 2, real impulse at 4
    stage_sel = 2'd2;
    for (int i = 0; i < WORDS; i++) begin in_frame[i] = '0; exp_frame[i] = '0; end
    in_frame[4]  = 32'h00010000;
    exp_frame[0] = 32'h00010000;
    exp_frame[4] = 32'hFFFF0000;
    apply_stimulus(WORDS, 0);
    check_output("s2_imp4", -1, 0);

    // Stage 2, real impulse at 5 exercises the W1 twiddle
    for (int i = 0; i < WORDS; i++) begin in_frame[i] = '0; exp_frame[i] = '0; end
    in_frame[5]   = 32'h00010000;
    exp_frame[1]  = 32'h0000B504;
    exp_frame[9]  = 32'hFFFF4AFC;
    exp_frame[5]  = 32'hFFFF4AFC;
    exp_frame[13] = 32'h0000B504;
    apply_stimulus(WORDS, 0);
    check_output("s2_imp5", -1, 0);

    // Bypass ramp; output valid right after the last acceptance
    bypass    = 1'b1;
    stage_sel = 2'd0;
    for (int i = 0; i < WORDS; i++) begin in_frame[i] = 32'(i); exp_frame[i] = 32'(i); end
    apply_stimulus(WORDS, 0);
    check_val("byp_lat", {31'b0, bus.send_val}, 32'd1);
    check_output("byp_ramp", -1, 0);

    // Out-of-range stage behaves as bypass
    bypass    = 1'b0;
    stage_sel = 2'd3;
    for (int i = 0; i < WORDS; i++) begin in_frame[i] = 32'(100 - i); exp_frame[i] = 32'(100 - i); end
    apply_stimulus(WORDS, 0);
    check_val("sel3_lat", {31'b0, bus.send_val}, 32'd1);
    check_output("sel3_byp", -1, 0);

    // Backpressure on both sides, stage 1
    stage_sel = 2'd1;
    for (int i = 0; i < WORDS; i++) in_frame[i] = $urandom;
    compute_ref(1, 1'b0);
    apply_stimulus(WORDS, 2);
    check_output("bp_s1", 5, 5);

    // Back-to-back frames: stage 0 then stage 1
    stage_sel = 2'd0;
    for (int i = 0; i < WORDS; i++) in_frame[i] = $urandom;
    compute_ref(0, 1'b0);
    apply_stimulus(WORDS, 0);
    check_output("b2b_s0", -1, 0);
    stage_sel = 2'd1;
    for (int i = 0; i < WORDS; i++) in_frame[i] = $urandom;
    compute_ref(1, 1'b0);
    apply_stimulus(WORDS, 0);
    check_output("b2b_s1", -1, 0);

    // Reset after five words discards the partial frame
    stage_sel = 2'd2;
    for (int i = 0; i < WORDS; i++) in_frame[i] = 32'hDEAD0000 + 32'(i);
    apply_stimulus(5, 0);
    reset = 1'b0;
    #1;
    check_val("midrst_recv_rdy", {31'b0, bus.recv_rdy}, 32'd0);
    check_val("midrst_send_val", {31'b0, bus.send_val}, 32'd0);
    step();
    check_val("midrst_recv_rdy_hold", {31'b0, bus.recv_rdy}, 32'd0);
    reset = 1'b1;
    step();
    check_val("midrst_rdy_after", {31'b0, bus.recv_rdy}, 32'd1);
    for (int i = 0; i < WORDS; i++) in_frame[i] = $urandom;
    compute_ref(2, 1'b0);
    apply_stimulus(WORDS, 1);
    check_output("after_rst_s2", -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
